// File: rtl/vec_mem_ctrl_pkg.sv
// Shared types for the vector memory controller: FSM states, lane count and lane array.
package vec_mem_pkg;
    localparam int LANES  = 4;
    localparam int DATA_W = 32;

    typedef logic [LANES-1:0][DATA_W-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE, RD, WAIT, OP, RES, WR, ADV, FIN
    } state_t;
endpackage

// File: rtl/vec_mem_ctrl_if.sv
// Memory bus plus operand/result handshakes between controller, Memory and datapath.
interface vec_mem_ctrl_if #(parameter int W = 32);
    logic         mem_wr_wom;
    logic [W-1:0] mem_i, mem_j, mem_n;
    logic         mem_algorithm;
    logic [W-1:0] mem_load1, mem_load2, mem_load3, mem_load4;
    logic [W-1:0] mem_result1, mem_result2, mem_result3, mem_result4;
    logic         op_valid, op_ready;
    logic [W-1:0] op_a1, op_a2, op_a3, op_a4;
    logic         res_valid, res_ready;
    logic [W-1:0] res1, res2, res3, res4;

    modport master (
        output mem_wr_wom, mem_i, mem_j, mem_n, mem_algorithm,
        input  mem_load1, mem_load2, mem_load3, mem_load4,
        output mem_result1, mem_result2, mem_result3, mem_result4,
        output op_valid, op_a1, op_a2, op_a3, op_a4,
        input  op_ready,
        input  res_valid, res1, res2, res3, res4,
        output res_ready
    );

    modport slave (
        input  mem_wr_wom, mem_i, mem_j, mem_n, mem_algorithm,
        output mem_load1, mem_load2, mem_load3, mem_load4,
        input  mem_result1, mem_result2, mem_result3, mem_result4,
        input  op_valid, op_a1, op_a2, op_a3, op_a4,
        output op_ready,
        output res_valid, res1, res2, res3, res4,
        input  res_ready
    );
endinterface

// File: rtl/vec_mem_ctrl_idx_gen.sv
// Row/column index generator for the n x n sweep; j steps by LANES, wraps into i.
module vec_mem_idx_gen
    import vec_mem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         adv,
    input  logic [W-1:0] n,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic         last
);
    logic [W-1:0] i_q, j_q;
    logic [W:0]   j_nx;
    logic         wrap;

    // One extra bit so j+LANES never wraps before the compare.
    assign j_nx = {1'b0, j_q} + (W+1)'(LANES);
    assign wrap = j_nx >= {1'b0, n};
    assign last = wrap && (i_q == n - W'(1));
    assign i    = i_q;
    assign j    = j_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
        end else if (init) begin
            i_q <= '0;
            j_q <= '0;
        end else if (adv) begin
            if (wrap) begin
                j_q <= '0;
                i_q <= i_q + W'(1);
            end else begin
                j_q <= j_nx[W-1:0];
            end
        end
    end
endmodule

// File: rtl/vec_mem_ctrl.sv
// Sweeps an n x n space in 4-lane groups: read, hand to datapath, take result, write back.
module vec_mem_ctrl
    import vec_mem_pkg::*;
#(
    parameter int W      = 32,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   n,
    input  logic           algorithm,
    output logic           busy,
    output logic           done,
    output logic           err,
    vec_mem_ctrl_if.master bus
);
    state_t                   state_q, state_d;
    logic [W-1:0]             n_q;
    logic                     alg_q, err_q;
    logic [2:0]               cnt_q;
    logic [LANES-1:0][W-1:0]  op_q, res_q, load_v, res_v;
    logic                     accept, idx_init, idx_adv, last;
    logic [W-1:0]             idx_i, idx_j;

    assign accept = (state_q == IDLE) && start;
    assign load_v = {bus.mem_load4, bus.mem_load3, bus.mem_load2, bus.mem_load1};
    assign res_v  = {bus.res4, bus.res3, bus.res2, bus.res1};

    vec_mem_idx_gen #(.W(W)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .init (idx_init),
        .adv  (idx_adv),
        .n    (n_q),
        .i    (idx_i),
        .j    (idx_j),
        .last (last)
    );

    always_comb begin
        state_d  = state_q;
        idx_init = 1'b0;
        idx_adv  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                // Zero or non-multiple-of-4 sizes finish without touching memory.
                if (n == '0 || n[1:0] != 2'b00) begin
                    state_d = FIN;
                end else begin
                    idx_init = 1'b1;
                    state_d  = RD;
                end
            end
            RD:   state_d = WAIT;
            WAIT: if (cnt_q == 3'd1) state_d = OP;
            OP:   if (bus.op_ready) state_d = RES;
            RES:  if (bus.res_valid) state_d = WR;
            WR:   state_d = ADV;
            ADV: begin
                idx_adv = 1'b1;
                state_d = last ? FIN : RD;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            alg_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                n_q   <= n;
                alg_q <= algorithm;
                err_q <= (n[1:0] != 2'b00);
            end
            case (state_q)
                RD:   cnt_q <= 3'(RD_LAT);
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) op_q <= load_v;
                end
                RES:  if (bus.res_valid) res_q <= res_v;
                default: ;
            endcase
        end
    end

    assign busy              = (state_q != IDLE) && (state_q != FIN);
    assign done              = (state_q == FIN);
    assign err               = err_q;
    assign bus.mem_wr_wom    = (state_q == WR);
    assign bus.mem_i         = idx_i;
    assign bus.mem_j         = idx_j;
    assign bus.mem_n         = n_q;
    assign bus.mem_algorithm = alg_q;
    assign bus.op_valid      = (state_q == OP);
    assign bus.res_ready     = (state_q == RES);
    assign {bus.op_a4, bus.op_a3, bus.op_a2, bus.op_a1} = op_q;
    assign {bus.mem_result4, bus.mem_result3, bus.mem_result2, bus.mem_result1} = res_q;
endmodule
